adder_result_fifo: RTL and testbench
====================================

Name: adder_result_fifo

Overview:
Downstream stage of the registered add/sub unit; captures each valid {cout, SUM, addsub} result into a small first-word-fall-through FIFO. Decouples the adder, which produces one result per cycle with no backpressure, from a consumer that accepts results via a valid/ready handshake. Flags loss of a result when a write arrives while full and not draining.

Parameters:
BIT, 3, data width; matches the adder's BIT.
DEPTH, 4, number of entries; power of two, >= 2.
PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge.
nrst  input  1  reset, asynchronous, active-low.
in_valid  input  1  SUM/cout/addsub this cycle hold a result to store.
addsub  input  1  op tag of the result: 0 = add, 1 = sub.
SUM  input  BIT  adder sum output.
cout  input  1  adder carry/borrow output.
out_ready  input  1  consumer accepts the head entry this cycle.
out_valid  output  1  head entry is valid (FIFO not empty).
out_sum  output  BIT  head entry sum.
out_cout  output  1  head entry carry.
out_op  output  1  head entry op tag.
count  output  PTR_W+1  entries held, 0..DEPTH.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
drop_err  output  1  sticky: a result was lost.

Behaviour:
- Reset (nrst low, async): wr_ptr = 0, rd_ptr = 0, count = 0, storage cleared to 0, drop_err = 0. Outputs: out_valid = 0, empty = 1, full = 0, out_sum = 0, out_cout = 0, out_op = 0. Asserting reset mid-operation discards all entries immediately, with no clock edge needed.
- Entry format is {op, cout, sum}, BIT+2 bits wide, stored unmodified. No arithmetic is done here.
- Alignment: upstream drives in_valid in the same cycle SUM/cout carry the registered result. This block adds no alignment delay.
- push = in_valid && (!full || pop). pop = out_valid && out_ready.
- On push at the rising edge: write the entry at wr_ptr, then wr_ptr++ (wraps DEPTH-1 -> 0).
- On pop at the rising edge: rd_ptr++ (wraps DEPTH-1 -> 0).
- count update: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- FWFT: out_sum/out_cout/out_op = storage[rd_ptr] combinationally; out_valid = !empty.
- Latency: an entry pushed at edge N is visible on the outputs after edge N, i.e. in the next cycle.
- Empty: out_ready is ignored (no pop). Simultaneous in_valid and out_ready while empty gives a push only; the entry appears next cycle. There is no bypass.
- Full with out_ready=1: pop and push both happen in the same edge; count stays DEPTH and no drop occurs.
- Full with out_ready=0 and in_valid=1: the entry is discarded. Storage and pointers are unchanged, and drop_err is set at that edge. drop_err stays set until reset.
- full, empty and count are derived from registered count; no combinational path from inputs.
- Pointer wrap: pointers are PTR_W bits and wrap naturally. count disambiguates full from empty.

Decomposition:
- Shared package adder_pkg: BIT default, DEPTH default, OP_ADD = 1'b0, OP_SUB = 1'b1, entry width constant BIT+2.
- One sub-module, fifo_wrap_ptr: PTR_W-bit counter with async active-low reset and increment enable. Instantiated twice, for write and read pointers.
- Storage, count and drop logic stay in the top module.

Test Plan:
- Reset: hold nrst=0 for 18 time units with random inputs -> out_valid=0, empty=1, full=0, count=0, drop_err=0, out_sum=0. Pulse nrst=0 mid-run after 2 pushes -> count=0 and empty=1 without waiting for a clock edge.
- Single result: push {add, cout=0, SUM=3'b011} with out_ready=0 -> next cycle out_valid=1, out_sum=3, out_cout=0, out_op=0, count=1. Set out_ready=1 -> after the edge, empty=1.
- Ordering and wrap: push 3, 4(cout=0, sum=3'b100), 7, then sub 3; pop all; push 3 more -> each read matches write order, pointers wrap past 3 to 0, count tracks 0..4.
- Full with no read: fill 4 entries, then push sum=6 with out_ready=0 -> full=1, count=4, drop_err=1, head unchanged, and 6 is never read out.
- Full with simultaneous read: with 4 entries and in_valid=out_ready=1, push sum=5 -> count stays 4, drop_err stays 0, old head is removed, 5 becomes the last entry.
- Empty with simultaneous events: count=0, in_valid=1, out_ready=1, sum=2 -> no pop; next cycle out_valid=1, out_sum=2, count=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the add/sub unit and its result FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package adder_pkg;

    // Default data width of the adder and default depth of the result FIFO.
    localparam int DEF_BIT   = 3;
    localparam int DEF_DEPTH = 4;

    // Entry layout is {op, cout, sum}, so an entry is the sum plus two tag bits.
    localparam int DEF_ENTRY_W = DEF_BIT + 2;

    // Operation tag carried alongside each result.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Default-width view of one stored result.
    typedef struct packed {
        logic               op;
        logic               cout;
        logic [DEF_BIT-1:0] sum;
    } entry_t;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Wrapping FIFO pointer: W-bit counter advanced by one when inc is high.
// Latency: new value visible the cycle after the enabling edge.
// Backpressure: none; caller gates inc.
module fifo_wrap_ptr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Pointer advances on inc and wraps naturally at 2**W.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/adder_result_fifo.sv
// First-word-fall-through FIFO holding {op, cout, sum} results from the adder.
// Latency: an entry written at edge N appears on the outputs in cycle N+1; no bypass.
// Backpressure: none upstream; a write while full and not draining is dropped and flagged in drop_err.
module adder_result_fifo
    import adder_pkg::*;
#(
    parameter  int BIT   = DEF_BIT,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    input  logic             addsub,
    input  logic [BIT-1:0]   SUM,
    input  logic             cout,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [BIT-1:0]   out_sum,
    output logic             out_cout,
    output logic             out_op,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty,
    output logic             drop_err
);

    localparam int             ENT_W    = BIT + 2;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [ENT_W-1:0] mem [DEPTH];
    logic [ENT_W-1:0] head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic             push;
    logic             pop;
    logic             drop;

    // Status flags come straight from the registered count, never from inputs.
    assign count     = count_q;
    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign out_valid = !empty;

    // A pop frees a slot in the same edge, so a full FIFO that is draining
    // still accepts the incoming result.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;

    // Head entry falls through combinationally from the read pointer.
    assign head     = mem[rd_ptr];
    assign out_op   = head[ENT_W-1];
    assign out_cout = head[BIT];
    assign out_sum  = head[BIT-1:0];

    fifo_wrap_ptr #(
        .W (PTR_W)
    ) u_wr_ptr (
        .clk  (clk),
        .nrst (nrst),
        .inc  (push),
        .ptr  (wr_ptr)
    );

    fifo_wrap_ptr #(
        .W (PTR_W)
    ) u_rd_ptr (
        .clk  (clk),
        .nrst (nrst),
        .inc  (pop),
        .ptr  (rd_ptr)
    );

    // Storage: cleared on reset so the outputs read zero while empty after reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= {addsub, cout, SUM};
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky loss flag: once a result is discarded it stays set until reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            drop_err <= 1'b0;
        end else if (drop) begin
            drop_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed, table-driven bench for adder_result_fifo with BIT=3, DEPTH=4.
// Each row drives one cycle and states the outputs expected after that edge.
// Reset behaviour is checked by hand-written sequences before and after the table.
module tb_adder_result_fifo;
    import adder_pkg::*;

    logic       clk;
    logic       nrst;
    logic       in_valid;
    logic       addsub;
    logic [2:0] sum;
    logic       cout;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_sum;
    logic       out_cout;
    logic       out_op;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       drop_err;

    int n_tests;
    int n_fail;

    adder_result_fifo #(
        .BIT   (3),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_valid  (in_valid),
        .addsub    (addsub),
        .SUM       (sum),
        .cout      (cout),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_op    (out_op),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic       op;
        logic       c;
        logic [2:0] s;
        logic       rdy;
        logic       e_vld;
        logic [2:0] e_cnt;
        logic       e_full;
        logic       e_empty;
        logic       e_drop;
        logic       chk_head;
        logic [2:0] e_sum;
        logic       e_cout;
        logic       e_op;
    } vec_t;

    localparam int NV = 34;
    vec_t tbl [NV];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Status-only row: the FIFO is empty afterwards or data is not of interest.
    function automatic vec_t vs(input logic iv, input logic op, input logic c, input logic [2:0] s,
                                input logic rdy, input logic [2:0] cnt, input logic drop);
        vec_t v;
        v.iv = iv; v.op = op; v.c = c; v.s = s; v.rdy = rdy;
        v.e_cnt = cnt; v.e_vld = (cnt != 0); v.e_full = (cnt == 4); v.e_empty = (cnt == 0);
        v.e_drop = drop; v.chk_head = 1'b0; v.e_sum = '0; v.e_cout = 1'b0; v.e_op = 1'b0;
        return v;
    endfunction

    // Row that also checks the head entry {op, cout, sum}.
    function automatic vec_t vh(input logic iv, input logic op, input logic c, input logic [2:0] s,
                                input logic rdy, input logic [2:0] cnt, input logic drop,
                                input logic [2:0] hs, input logic hc, input logic ho);
        vec_t v;
        v = vs(iv, op, c, s, rdy, cnt, drop);
        v.chk_head = 1'b1; v.e_sum = hs; v.e_cout = hc; v.e_op = ho;
        return v;
    endfunction

    task automatic check_status(input string tag, input logic vld, input logic [2:0] cnt,
                                input logic fl, input logic em, input logic dr);
        chk({tag, ".out_valid"}, int'(out_valid), int'(vld));
        chk({tag, ".count"},     int'(count),     int'(cnt));
        chk({tag, ".full"},      int'(full),      int'(fl));
        chk({tag, ".empty"},     int'(empty),     int'(em));
        chk({tag, ".drop_err"},  int'(drop_err),  int'(dr));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Single result, then pop it.
        tbl[0]  = vh(1, OP_ADD, 0, 3'd3, 0, 1, 0, 3'd3, 0, OP_ADD);
        tbl[1]  = vs(0, OP_ADD, 0, 3'd0, 1, 0, 0);
        // Ordering and wrap: fill to full across the pointer wrap, drain.
        tbl[2]  = vh(1, OP_ADD, 0, 3'd3, 0, 1, 0, 3'd3, 0, OP_ADD);
        tbl[3]  = vh(1, OP_ADD, 0, 3'd4, 0, 2, 0, 3'd3, 0, OP_ADD);
        tbl[4]  = vh(1, OP_ADD, 0, 3'd7, 0, 3, 0, 3'd3, 0, OP_ADD);
        tbl[5]  = vh(1, OP_SUB, 1, 3'd3, 0, 4, 0, 3'd3, 0, OP_ADD);
        tbl[6]  = vh(0, OP_ADD, 0, 3'd0, 1, 3, 0, 3'd4, 0, OP_ADD);
        tbl[7]  = vh(0, OP_ADD, 0, 3'd0, 1, 2, 0, 3'd7, 0, OP_ADD);
        tbl[8]  = vh(0, OP_ADD, 0, 3'd0, 1, 1, 0, 3'd3, 1, OP_SUB);
        tbl[9]  = vs(0, OP_ADD, 0, 3'd0, 1, 0, 0);
        tbl[10] = vh(1, OP_ADD, 1, 3'd1, 0, 1, 0, 3'd1, 1, OP_ADD);
        tbl[11] = vh(1, OP_SUB, 0, 3'd2, 0, 2, 0, 3'd1, 1, OP_ADD);
        tbl[12] = vh(1, OP_ADD, 0, 3'd5, 0, 3, 0, 3'd1, 1, OP_ADD);
        tbl[13] = vh(0, OP_ADD, 0, 3'd0, 1, 2, 0, 3'd2, 0, OP_SUB);
        tbl[14] = vh(0, OP_ADD, 0, 3'd0, 1, 1, 0, 3'd5, 0, OP_ADD);
        tbl[15] = vs(0, OP_ADD, 0, 3'd0, 1, 0, 0);
        // Empty with in_valid and out_ready together: push only, no bypass.
        tbl[16] = vh(1, OP_ADD, 0, 3'd2, 1, 1, 0, 3'd2, 0, OP_ADD);
        // Fill to full, then push while popping.
        tbl[17] = vh(1, OP_ADD, 0, 3'd4, 0, 2, 0, 3'd2, 0, OP_ADD);
        tbl[18] = vh(1, OP_SUB, 1, 3'd6, 0, 3, 0, 3'd2, 0, OP_ADD);
        tbl[19] = vh(1, OP_ADD, 0, 3'd1, 0, 4, 0, 3'd2, 0, OP_ADD);
        tbl[20] = vh(1, OP_ADD, 0, 3'd5, 1, 4, 0, 3'd4, 0, OP_ADD);
        tbl[21] = vh(0, OP_ADD, 0, 3'd0, 1, 3, 0, 3'd6, 1, OP_SUB);
        tbl[22] = vh(0, OP_ADD, 0, 3'd0, 1, 2, 0, 3'd1, 0, OP_ADD);
        tbl[23] = vh(0, OP_ADD, 0, 3'd0, 1, 1, 0, 3'd5, 0, OP_ADD);
        tbl[24] = vs(0, OP_ADD, 0, 3'd0, 1, 0, 0);
        // Full without a read: the extra result is lost and flagged.
        tbl[25] = vh(1, OP_ADD, 0, 3'd1, 0, 1, 0, 3'd1, 0, OP_ADD);
        tbl[26] = vh(1, OP_ADD, 0, 3'd2, 0, 2, 0, 3'd1, 0, OP_ADD);
        tbl[27] = vh(1, OP_ADD, 0, 3'd3, 0, 3, 0, 3'd1, 0, OP_ADD);
        tbl[28] = vh(1, OP_ADD, 0, 3'd4, 0, 4, 0, 3'd1, 0, OP_ADD);
        tbl[29] = vh(1, OP_SUB, 0, 3'd6, 0, 4, 1, 3'd1, 0, OP_ADD);
        tbl[30] = vh(0, OP_ADD, 0, 3'd0, 1, 3, 1, 3'd2, 0, OP_ADD);
        tbl[31] = vh(0, OP_ADD, 0, 3'd0, 1, 2, 1, 3'd3, 0, OP_ADD);
        tbl[32] = vh(0, OP_ADD, 0, 3'd0, 1, 1, 1, 3'd4, 0, OP_ADD);
        tbl[33] = vs(0, OP_ADD, 0, 3'd0, 1, 0, 1);

        // Reset held with random inputs.
        nrst = 1'b0;
        in_valid = 1'b0; addsub = 1'b0; sum = '0; cout = 1'b0; out_ready = 1'b0;
        for (int t = 0; t < 18; t++) begin
            in_valid  = 1'($urandom_range(0, 1));
            addsub    = 1'($urandom_range(0, 1));
            cout      = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            sum       = 3'($urandom_range(0, 7));
            #1;
        end
        check_status("rst", 0, 0, 0, 1, 0);
        chk("rst.out_sum", int'(out_sum), 0);

        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        nrst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            in_valid  = tbl[i].iv;
            addsub    = tbl[i].op;
            cout      = tbl[i].c;
            sum       = tbl[i].s;
            out_ready = tbl[i].rdy;
            @(posedge clk);
            #1;
            check_status($sformatf("v%0d", i), tbl[i].e_vld, tbl[i].e_cnt,
                         tbl[i].e_full, tbl[i].e_empty, tbl[i].e_drop);
            if (tbl[i].chk_head) begin
                chk($sformatf("v%0d.out_sum", i),  int'(out_sum),  int'(tbl[i].e_sum));
                chk($sformatf("v%0d.out_cout", i), int'(out_cout), int'(tbl[i].e_cout));
                chk($sformatf("v%0d.out_op", i),   int'(out_op),   int'(tbl[i].e_op));
            end
        end

        // Mid-run reset: two entries held, then reset between clock edges.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1; addsub = OP_ADD; cout = 1'b0; sum = 3'(k + 1); out_ready = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_status("pre_arst", 1, 2, 0, 0, 1);
        #2;
        nrst = 1'b0;
        #1;
        check_status("arst", 0, 0, 0, 1, 0);
        chk("arst.out_sum", int'(out_sum), 0);
        @(negedge clk);
        nrst = 1'b1;

        // Normal operation resumes after the asynchronous reset.
        @(negedge clk);
        in_valid = 1'b1; addsub = OP_SUB; cout = 1'b1; sum = 3'd7; out_ready = 1'b0;
        @(posedge clk);
        #1;
        check_status("post_arst", 1, 1, 0, 0, 0);
        chk("post_arst.out_sum", int'(out_sum), 7);
        chk("post_arst.out_op",  int'(out_op),  int'(OP_SUB));
        @(negedge clk);
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
